// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared types and constants for the 18-bit processor
package proc_pkg;

  localparam int INSTR_W = 18;

  localparam int OP_MSB  = 17;
  localparam int OP_LSB  = 14;
  localparam int RD_MSB  = 13;
  localparam int RD_LSB  = 10;
  localparam int RS1_MSB = 9;
  localparam int RS1_LSB = 6;
  localparam int RS2_MSB = 5;
  localparam int RS2_LSB = 2;
  localparam int IMM_MSB = 5;
  localparam int IMM_LSB = 0;

  localparam logic [3:0] OP_HALT = 4'hF;
  localparam logic [3:0] OP_JMP  = 4'hE;
  localparam logic [3:0] OP_BEZ  = 4'hD;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_WRITEBACK,
    S_HALT
  } state_t;

endpackage

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - program counter with increment and sign-extended relative branch
module pc_unit #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              branch,
  input  logic [5:0]        imm,
  output logic [ADDR_W-1:0] pc
);

  logic [ADDR_W-1:0] imm_sext;

  assign imm_sext = {{(ADDR_W-6){imm[5]}}, imm};

  // Both paths wrap naturally at ADDR_W bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= '0;
    end else if (inc) begin
      pc <= pc + 1'b1;
    end else if (branch) begin
      pc <= pc + imm_sext;
    end
  end

endmodule

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - multi-cycle fetch/decode sequencer driving the opcode decoder
module instr_sequencer
  import proc_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [17:0]       imem_rdata,
  input  logic              alu_z,
  output logic [3:0]        op_sel,
  output logic [3:0]        rd_sel,
  output logic [3:0]        rs1_sel,
  output logic [3:0]        rs2_sel,
  output logic [5:0]        imm,
  output logic              wb_en,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
);

  state_t             state;
  state_t             state_nxt;
  logic [INSTR_W-1:0] ir;
  logic               z_q;
  logic               ir_load;
  logic               pc_branch;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      ir    <= '0;
      z_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (ir_load) begin
        ir <= imem_rdata;
      end
      if (state == S_EXECUTE) begin
        z_q <= alu_z;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    ir_load   = 1'b0;
    pc_branch = 1'b0;
    imem_req  = 1'b0;
    wb_en     = 1'b0;
    halted    = 1'b0;
    case (state)
      S_IDLE: begin
        state_nxt = S_FETCH;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_load   = 1'b1;
          state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        state_nxt = S_EXECUTE;
      end
      S_EXECUTE: begin
        state_nxt = S_WRITEBACK;
      end
      S_WRITEBACK: begin
        state_nxt = S_FETCH;
        case (op_sel)
          OP_HALT: state_nxt = S_HALT;
          OP_JMP:  pc_branch = 1'b1;
          OP_BEZ:  pc_branch = z_q;
          default: wb_en     = 1'b1;
        endcase
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign op_sel  = ir[OP_MSB:OP_LSB];
  assign rd_sel  = ir[RD_MSB:RD_LSB];
  assign rs1_sel = ir[RS1_MSB:RS1_LSB];
  assign rs2_sel = ir[RS2_MSB:RS2_LSB];
  assign imm     = ir[IMM_MSB:IMM_LSB];

  assign imem_addr = pc;

  pc_unit #(
    .ADDR_W(ADDR_W)
  ) u_pc_unit (
    .clk    (clk),
    .rst    (rst),
    .inc    (ir_load),
    .branch (pc_branch),
    .imm    (imm),
    .pc     (pc)
  );

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - scoreboard bench for instr_sequencer
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [9:0]  imem_addr;
  logic        imem_ack;
  logic [17:0] imem_rdata;
  logic        alu_z;
  logic [3:0]  op_sel;
  logic [3:0]  rd_sel;
  logic [3:0]  rs1_sel;
  logic [3:0]  rs2_sel;
  logic [5:0]  imm;
  logic        wb_en;
  logic [9:0]  pc;
  logic        halted;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [3:0] op;
    logic [3:0] rd;
    logic [3:0] rs1;
    logic [3:0] rs2;
    logic [5:0] imm;
    logic       wb;
    logic       halt;
    logic [9:0] pc;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  instr_sequencer #(.ADDR_W(10)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .alu_z      (alu_z),
    .op_sel     (op_sel),
    .rd_sel     (rd_sel),
    .rs1_sel    (rs1_sel),
    .rs2_sel    (rs2_sel),
    .imm        (imm),
    .wb_en      (wb_en),
    .pc         (pc),
    .halted     (halted)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      passed++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    imem_ack = 1'b0;
    tick();
    tick();
    check("rst_req", imem_req, 0);
    check("rst_pc", pc, 0);
    check("rst_wb", wb_en, 0);
    check("rst_halted", halted, 0);
    rst = 1'b0;
    check("idle_req", imem_req, 0);
    tick();
    check("first_req", imem_req, 1);
  endtask

  // One full instruction from FETCH through WRITEBACK; bench computes fields from the word it drives.
  task automatic do_instr(input logic [17:0] word, input int delay, input logic z,
                          input logic spur, input logic [9:0] exp_addr, input logic [9:0] exp_pc);
    exp_t e;
    int   n;
    e.op   = word[17:14];
    e.rd   = word[13:10];
    e.rs1  = word[9:6];
    e.rs2  = word[5:2];
    e.imm  = word[5:0];
    e.wb   = !(e.op == 4'hF || e.op == 4'hE || e.op == 4'hD);
    e.halt = (e.op == 4'hF);
    e.pc   = exp_pc;
    n = 0;
    while (!imem_req && n < 8) begin
      tick();
      n++;
    end
    check("req_wait", imem_req, 1);
    check("fetch_addr", imem_addr, exp_addr);
    for (int i = 0; i < delay; i++) begin
      tick();
      check("stall_req", imem_req, 1);
      check("stall_addr", imem_addr, exp_addr);
    end
    imem_ack   = 1'b1;
    imem_rdata = word;
    exp_q.push_back(e);
    tick();
    imem_ack = 1'b0;
    e = exp_q.pop_front();
    check("dec_op", op_sel, e.op);
    check("dec_rd", rd_sel, e.rd);
    check("dec_rs1", rs1_sel, e.rs1);
    check("dec_rs2", rs2_sel, e.rs2);
    check("dec_imm", imm, e.imm);
    check("dec_wb", wb_en, 0);
    check("dec_req", imem_req, 0);
    if (spur) begin
      imem_ack   = 1'b1;
      imem_rdata = ~word;
    end
    tick();
    imem_ack = 1'b0;
    alu_z    = z;
    check("exe_wb", wb_en, 0);
    check("exe_op", op_sel, e.op);
    tick();
    alu_z = ~z;
    check("wb_en", wb_en, e.wb);
    check("wb_rd", rd_sel, e.rd);
    check("wb_imm", imm, e.imm);
    tick();
    check("post_wb", wb_en, 0);
    check("post_pc", pc, e.pc);
    check("post_req", imem_req, !e.halt);
    check("post_halted", halted, e.halt);
  endtask

  initial begin
    rst        = 1'b1;
    imem_ack   = 1'b0;
    imem_rdata = '0;
    alu_z      = 1'b0;
    do_reset();
    check("rst_op", op_sel, 0);
    check("rst_imm", imm, 0);

    do_instr(18'h04C45, 0, 1'b0, 1'b0, 10'h000, 10'h001);
    do_instr(18'h08000, 3, 1'b0, 1'b1, 10'h001, 10'h002);

    do_reset();
    do_instr(18'h3803E, 0, 1'b0, 1'b0, 10'h000, 10'h3FF);
    do_instr(18'h0C000, 0, 1'b0, 1'b0, 10'h3FF, 10'h000);

    do_instr(18'h38004, 0, 1'b0, 1'b0, 10'h000, 10'h005);
    do_instr(18'h34004, 0, 1'b1, 1'b0, 10'h005, 10'h00A);
    do_instr(18'h3803A, 1, 1'b1, 1'b0, 10'h00A, 10'h005);
    do_instr(18'h34004, 0, 1'b0, 1'b0, 10'h005, 10'h006);

    do_instr(18'h3C000, 0, 1'b0, 1'b0, 10'h006, 10'h007);
    for (int i = 0; i < 5; i++) begin
      imem_ack   = 1'b1;
      imem_rdata = 18'h04C45;
      tick();
      check("halt_req", imem_req, 0);
      check("halt_flag", halted, 1);
    end
    check("halt_ir", op_sel, 4'hF);
    imem_ack = 1'b0;

    do_reset();
    check("rst_after_halt_pc", pc, 0);

    imem_ack   = 1'b1;
    imem_rdata = 18'h3FFFF;
    rst        = 1'b1;
    tick();
    rst      = 1'b0;
    imem_ack = 1'b0;
    check("midrst_req", imem_req, 0);
    check("midrst_pc", pc, 0);
    check("midrst_op", op_sel, 0);
    check("midrst_imm", imm, 0);
    do_instr(18'h04C45, 0, 1'b0, 1'b1, 10'h000, 10'h001);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
